// File: rtl/lsu_if.sv
// Word-wide data-memory bus between the load/store unit and data memory.
// The request side is registered by the LSU; the memory returns one ack per request.
interface lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address plus funct3 into one word-bus
// transaction, stalls the core through busy, and returns an extended load value.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    lsu_if.master       mem
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t state, state_next;

    // Latched request and bus-side registers
    logic          req_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    size_t         size_q;
    logic          uns_q;
    logic [1:0]    off_q;
    logic [CW-1:0] cnt;

    // Response registers, only visible while done is high
    logic [31:0]   rdata_q;
    logic          mis_q;
    logic          err_q;

    // Decoded request and FSM strobes
    size_t         req_size;
    logic          req_mis;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;
    logic [31:0]   lane;
    logic [31:0]   load_value;
    logic          timer_last;
    logic          start;
    logic          reject;
    logic          ack_hit;
    logic          expire;

    // Illegal size encodings fall through to word.
    always_comb begin
        // NOTE: every combinationally driven signal gets a default first so no path infers a latch.
        req_size  = SZ_W;
        req_be    = 4'b1111;
        req_wdata = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                req_size  = SZ_B;
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                req_size  = SZ_H;
                req_be    = 4'b0011 << {addr[1], 1'b0};
                req_wdata = {2{wdata[15:0]}};
            end
            default: begin
                req_size  = SZ_W;
                req_be    = 4'b1111;
                req_wdata = wdata;
            end
        endcase
        req_mis = ((req_size == SZ_H) && addr[0]) ||
                  ((req_size == SZ_W) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        lane       = mem.mem_rdata >> {off_q, 3'b000};
        load_value = mem.mem_rdata;
        unique case (size_q)
            SZ_B:    load_value = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            SZ_H:    load_value = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_value = mem.mem_rdata;
        endcase
    end

    assign timer_last = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An ack in the same cycle as the last timeout count completes normally.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        start      = 1'b0;
        reject     = 1'b0;
        ack_hit    = 1'b0;
        expire     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    busy = 1'b1;
                    if (req_mis) begin
                        reject     = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        start      = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (mem.mem_ack) begin
                    ack_hit    = 1'b1;
                    state_next = ST_RESP;
                end else if (timer_last) begin
                    expire     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            off_q   <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (start) begin
                req_q   <= 1'b1;
                we_q    <= req_we;
                addr_q  <= {addr[31:2], 2'b00};
                be_q    <= req_be;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                uns_q   <= funct3[2];
                off_q   <= addr[1:0];
                cnt     <= '0;
            end else if (ack_hit || expire) begin
                req_q   <= 1'b0;
            end else if (state == ST_WAIT) begin
                cnt     <= cnt + 1'b1;
            end

            if (reject) begin
                rdata_q <= '0;
                mis_q   <= 1'b1;
                err_q   <= 1'b0;
            end else if (ack_hit) begin
                rdata_q <= we_q ? 32'h0 : load_value;
                mis_q   <= 1'b0;
                err_q   <= 1'b0;
            end else if (expire) begin
                rdata_q <= '0;
                mis_q   <= 1'b0;
                err_q   <= 1'b1;
            end
        end
    end

    assign done       = (state == ST_RESP);
    assign rdata      = done ? rdata_q : 32'h0;
    assign misaligned = done & mis_q;
    assign bus_err    = done & err_q;

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: each access pushes its expected response onto a
// scoreboard that is popped when done pulses; bus fields are checked every WAIT cycle.
module tb_lsu;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_err;

    lsu_if bus ();

    lsu #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem        (bus.master)
    );

    always #5 clk = ~clk;

    int    cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int    tests = 0;
    int    fails = 0;
    int    last_done;
    int    last_first_req;
    int    d1;
    resp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // IDLE cycle that follows done. ack_on = WAIT cycle carrying the ack, 0 = never.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_on, input logic [31:0] rd,
                          input logic [31:0] x_addr, input logic [3:0] x_be,
                          input logic [31:0] x_wdata, input int x_done,
                          input logic [31:0] x_rdata, input logic x_mis, input logic x_err);
        resp_t e;
        int    t0;
        int    busy_n;
        int    req_n;
        logic  seen;
        e.rdata = x_rdata;
        e.mis   = x_mis;
        e.err   = x_err;
        sb.push_back(e);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        t0        = cycle;
        busy_n    = 0;
        req_n     = 0;
        seen      = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            #1;
            if (busy) busy_n++;
            if (done) begin
                check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
                e = sb.pop_front();
                check({tag, "_done_at"}, 64'(cycle - t0), 64'(x_done));
                check({tag, "_rdata"}, 64'(rdata), 64'(e.rdata));
                check({tag, "_misaligned"}, 64'(misaligned), 64'(e.mis));
                check({tag, "_bus_err"}, 64'(bus_err), 64'(e.err));
                check({tag, "_busy_in_resp"}, 64'(busy), 64'd0);
                last_done = cycle;
                seen      = 1'b1;
                req_valid = 1'b0;
            end else begin
                check({tag, "_quiet_outs"}, {30'b0, misaligned, bus_err, rdata}, 64'd0);
                if (bus.mem_req) begin
                    req_n++;
                    if (req_n == 1) begin
                        last_first_req = cycle;
                        check({tag, "_req_at"}, 64'(cycle - t0), 64'd1);
                    end
                    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(x_addr));
                    check({tag, "_mem_be"}, 64'(bus.mem_be), 64'(x_be));
                    check({tag, "_mem_we"}, 64'(bus.mem_we), 64'(we));
                    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(x_wdata));
                    if (req_n == ack_on) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = rd;
                    end
                end
            end
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(x_done));
        check({tag, "_req_cycles"}, 64'(req_n), 64'(x_mis ? 0 : x_done - 1));
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        funct3        = 3'b000;
        addr          = 32'h0;
        wdata         = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_resp", {30'b0, misaligned, bus_err, rdata}, 64'd0);
        check("rst_bus_ctl", {58'b0, bus.mem_req, bus.mem_we, bus.mem_be}, 64'd0);
        check("rst_bus_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_bus_wdata", 64'(bus.mem_wdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        //     tag      we    f3      addr          wdata         ack rd            mem_addr      be       mem_wdata     done rdata         mis   err
        access("lb",    1'b0, 3'b000, 32'h0000_1003, 32'h0,        1, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'h0,        2, 32'hFFFF_FF80, 1'b0, 1'b0);
        access("lbu",   1'b0, 3'b100, 32'h0000_1003, 32'h0,        1, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'h0,        2, 32'h0000_0080, 1'b0, 1'b0);
        access("sh",    1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 3, 32'hFFFF_FFFF, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 4, 32'h0,        1'b0, 1'b0);
        access("sb",    1'b1, 3'b000, 32'h0000_5001, 32'h1234_56A5, 2, 32'h0,        32'h0000_5000, 4'b0010, 32'hA5A5_A5A5, 3, 32'h0,        1'b0, 1'b0);
        access("lw_mis",1'b0, 3'b010, 32'h0000_3001, 32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 32'h0,        1'b1, 1'b0);
        access("lh_mis",1'b0, 3'b001, 32'h0000_3001, 32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 32'h0,        1'b1, 1'b0);
        access("lh",    1'b0, 3'b001, 32'h0000_3002, 32'h0,        1, 32'h8001_0000, 32'h0000_3000, 4'b1100, 32'h0,        2, 32'hFFFF_8001, 1'b0, 1'b0);
        access("lhu",   1'b0, 3'b101, 32'h0000_3002, 32'h0,        1, 32'h8001_0000, 32'h0000_3000, 4'b1100, 32'h0,        2, 32'h0000_8001, 1'b0, 1'b0);
        access("f3_011",1'b0, 3'b011, 32'h0000_6002, 32'h0,        1, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 32'h0,        1'b1, 1'b0);
        access("f3_111",1'b0, 3'b111, 32'h0000_6004, 32'h0,        1, 32'h8765_4321, 32'h0000_6004, 4'b1111, 32'h0,        2, 32'h8765_4321, 1'b0, 1'b0);
        access("lw_to", 1'b0, 3'b010, 32'h0000_4000, 32'h0,        0, 32'h0,        32'h0000_4000, 4'b1111, 32'h0,        5, 32'h0,        1'b0, 1'b1);

        // A stray ack after the timeout must not produce a response.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        check("late_ack_busy", 64'(busy), 64'd0);
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        check("late_ack_done", 64'(done), 64'd0);
        check("late_ack_req", 64'(bus.mem_req), 64'd0);
        @(negedge clk);

        // Reset in the middle of WAIT abandons the access.
        req_valid = 1'b1;
        req_we    = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h0000_0040;
        repeat (2) @(negedge clk);
        #1;
        check("mid_rst_req_before", 64'(bus.mem_req), 64'd1);
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_req", 64'(bus.mem_req), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        reset         = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        check("mid_rst_late_done", 64'(done), 64'd0);
        check("mid_rst_late_req", 64'(bus.mem_req), 64'd0);
        @(negedge clk);

        // Back-to-back loads: the IDLE cycle right after done accepts the next one,
        // so its mem_req appears two cycles after the first done.
        access("b2b_0", 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1, 32'hAAAA_5555, 32'h0000_0010, 4'b1111, 32'h0, 2, 32'hAAAA_5555, 1'b0, 1'b0);
        d1 = last_done;
        access("b2b_1", 1'b0, 3'b010, 32'h0000_0014, 32'h0, 1, 32'h1234_5678, 32'h0000_0014, 4'b1111, 32'h0, 2, 32'h1234_5678, 1'b0, 1'b0);
        check("b2b_gap", 64'(last_first_req - d1), 64'd2);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
